// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, ALU operations,
// opcodes, mux selects and the branch-condition evaluator.
package multicycle_control_unit_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Returns {illegal, taken} for a conditional branch with the given funct3.
    function automatic logic [1:0] branch_eval(
        input logic [2:0] funct3,
        input logic       zero,
        input logic       negative,
        input logic       carry,
        input logic       overflow
    );
        logic [1:0] res;
        res = 2'b00;
        case (funct3)
            3'b000:  res = {1'b0, zero};
            3'b001:  res = {1'b0, ~zero};
            3'b100:  res = {1'b0, negative ^ overflow};
            3'b101:  res = {1'b0, ~(negative ^ overflow)};
            3'b110:  res = {1'b0, ~carry};
            3'b111:  res = {1'b0, carry};
            default: res = 2'b10;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp plus the funct fields to an ALU operation
// and flags funct3 values the datapath does not implement.
module alu_decoder
    import multicycle_control_unit_pkg::*;
(
    input  logic [6:0] Opcode,
    input  logic [2:0] Funct3,
    input  logic       Funct7b5,
    input  logic [1:0] ALUOp,
    output logic [2:0] ALUControl,
    output logic       illegal_funct
);

    logic w_is_sub;

    // Only R-type uses bit 30 to pick subtract; addi ignores it.
    assign w_is_sub = (Opcode == OP_RTYPE) && Funct7b5;

    // Operation select
    always_comb begin
        ALUControl    = ALU_ADD;
        illegal_funct = 1'b0;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (Funct3)
                    3'b000:  ALUControl = w_is_sub ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b100:  ALUControl = ALU_XOR;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: begin
                        ALUControl    = ALU_ADD;
                        illegal_funct = 1'b1;
                    end
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V style control FSM. Outputs are combinational from the state
// and live inputs; write enables and Illegal are forced low while rst is high.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Opcode,
    input  logic [2:0] Funct3,
    input  logic       Funct7b5,
    input  logic       Zero,
    input  logic       Negative,
    input  logic       Carry,
    input  logic       OverFlow,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       Illegal
);

    state_t     r_state;
    state_t     w_next;
    logic       w_pcwrite;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;
    logic       w_illegal;
    logic [1:0] w_aluop;
    logic       w_illegal_funct;
    logic [1:0] w_branch;

    assign w_branch = branch_eval(Funct3, Zero, Negative, Carry, OverFlow);

    alu_decoder u_alu_decoder (
        .Opcode        (Opcode),
        .Funct3        (Funct3),
        .Funct7b5      (Funct7b5),
        .ALUOp         (w_aluop),
        .ALUControl    (ALUControl),
        .illegal_funct (w_illegal_funct)
    );

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_next     = r_state;
        w_pcwrite  = 1'b0;
        AdrSrc     = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_REG;
        ImmSrc     = IMM_I;
        w_aluop    = ALUOP_ADD;
        w_illegal  = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                w_irwrite = MemReady;
                w_pcwrite = MemReady;
                w_next    = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Precompute PC-relative branch/jump target into ALUOut.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_B;
                case (Opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECR;
                    OP_ITYPE:          w_next = S_EXECI;
                    OP_BRANCH:         w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
                if (Opcode == OP_STORE) begin
                    ImmSrc = IMM_S;
                    w_next = S_MEMWRITE;
                end else begin
                    ImmSrc = IMM_I;
                    w_next = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                w_next = MemReady ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
                w_next     = MemReady ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA   = SRCA_REG;
                ALUSrcB   = SRCB_REG;
                w_aluop   = ALUOP_FUNCT;
                w_illegal = w_illegal_funct;
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA   = SRCA_REG;
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_I;
                w_aluop   = ALUOP_FUNCT;
                w_illegal = w_illegal_funct;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA   = SRCA_REG;
                ALUSrcB   = SRCB_REG;
                w_aluop   = ALUOP_SUB;
                w_pcwrite = w_branch[0];
                w_illegal = w_branch[1];
                w_next    = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while rd gets OldPC+4 next cycle.
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                w_pcwrite = 1'b1;
                w_next    = S_ALUWB;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    assign PCWrite  = w_pcwrite  & ~rst;
    assign MemWrite = w_memwrite & ~rst;
    assign IRWrite  = w_irwrite  & ~rst;
    assign RegWrite = w_regwrite & ~rst;
    assign Illegal  = w_illegal  & ~rst;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: directed cycles push expected
// output vectors; a negedge monitor pops and compares them.
module tb_multicycle_control_unit;

    logic       clk;
    logic       rst;
    logic [6:0] Opcode;
    logic [2:0] Funct3;
    logic       Funct7b5;
    logic       Zero;
    logic       Negative;
    logic       Carry;
    logic       OverFlow;
    logic       MemReady;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       Illegal;

    typedef struct {
        string       name;
        logic [16:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        checks = 0;
    int        errors = 0;

    multicycle_control_unit dut (
        .clk        (clk),
        .rst        (rst),
        .Opcode     (Opcode),
        .Funct3     (Funct3),
        .Funct7b5   (Funct7b5),
        .Zero       (Zero),
        .Negative   (Negative),
        .Carry      (Carry),
        .OverFlow   (OverFlow),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .Illegal    (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector layout: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,Illegal}
    function automatic logic [16:0] e_fetch(input logic mr);
        return {mr, 1'b0, 1'b0, mr, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0};
    endfunction
    function automatic logic [16:0] e_decode(input logic ill);
        return {5'b00000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, ill};
    endfunction
    function automatic logic [16:0] e_execr(input logic [2:0] alu);
        return {5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, alu, 1'b0};
    endfunction
    function automatic logic [16:0] e_execi(input logic [2:0] alu, input logic ill);
        return {5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, alu, ill};
    endfunction
    function automatic logic [16:0] e_aluwb();
        return {5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    endfunction
    function automatic logic [16:0] e_memadr(input logic [1:0] imm);
        return {5'b00000, 2'b00, 2'b10, 2'b01, imm, 3'b000, 1'b0};
    endfunction
    function automatic logic [16:0] e_memread();
        return {5'b01000, 12'b0};
    endfunction
    function automatic logic [16:0] e_memwb();
        return {5'b00001, 2'b01, 10'b0};
    endfunction
    function automatic logic [16:0] e_memwrite(input logic mw);
        return {1'b0, 1'b1, mw, 2'b00, 12'b0};
    endfunction
    function automatic logic [16:0] e_branch(input logic t, input logic ill);
        return {t, 4'b0000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, ill};
    endfunction
    function automatic logic [16:0] e_jal();
        return {5'b10000, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000, 1'b0};
    endfunction

    // Inputs are already applied for this cycle: queue its expectation, then advance.
    task automatic step(input string nm, input logic [16:0] e);
        sb_entry_t ent;
        ent.name = nm;
        ent.exp  = e;
        sb_q.push_back(ent);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        Opcode   = op;
        Funct3   = f3;
        Funct7b5 = f7;
    endtask

    // Monitor: outputs are combinational, so every cycle presents a result.
    always @(negedge clk) begin
        logic [16:0] act;
        sb_entry_t   ent;
        if (sb_q.size() > 0) begin
            ent = sb_q.pop_front();
            act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                   ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal};
            checks++;
            if (act !== ent.exp) begin
                errors++;
                $display("FAIL %s: got %05h expected %05h", ent.name, act, ent.exp);
            end
        end
    end

    initial begin
        rst = 1'b1;
        set_instr(7'b1111111, 3'b000, 1'b0);
        Zero = 1'b0; Negative = 1'b0; Carry = 1'b0; OverFlow = 1'b0;
        MemReady = 1'b1;
        @(posedge clk);
        #1;

        // Reset held: FETCH outputs with all enables suppressed
        step("reset_fetch", e_fetch(1'b0));
        rst = 1'b0;

        // add
        set_instr(7'b0110011, 3'b000, 1'b0);
        step("add_fetch", e_fetch(1'b1));
        step("add_decode", e_decode(1'b0));
        step("add_execr", e_execr(3'b000));
        step("add_aluwb", e_aluwb());

        // sub
        set_instr(7'b0110011, 3'b000, 1'b1);
        step("sub_fetch", e_fetch(1'b1));
        step("sub_decode", e_decode(1'b0));
        step("sub_execr", e_execr(3'b001));
        step("sub_aluwb", e_aluwb());

        // addi with bit30 set stays add
        set_instr(7'b0010011, 3'b000, 1'b1);
        step("addi_fetch", e_fetch(1'b1));
        step("addi_decode", e_decode(1'b0));
        step("addi_execi", e_execi(3'b000, 1'b0));
        step("addi_aluwb", e_aluwb());

        // xor R-type, then I-type with unsupported funct3 001
        set_instr(7'b0110011, 3'b100, 1'b0);
        step("xor_fetch", e_fetch(1'b1));
        step("xor_decode", e_decode(1'b0));
        step("xor_execr", e_execr(3'b100));
        step("xor_aluwb", e_aluwb());
        set_instr(7'b0010011, 3'b001, 1'b0);
        step("slli_fetch", e_fetch(1'b1));
        step("slli_decode", e_decode(1'b0));
        step("slli_execi", e_execi(3'b000, 1'b1));
        step("slli_aluwb", e_aluwb());

        // andi / ori / slti in EXECI
        set_instr(7'b0010011, 3'b111, 1'b0);
        step("andi_fetch", e_fetch(1'b1));
        step("andi_decode", e_decode(1'b0));
        step("andi_execi", e_execi(3'b010, 1'b0));
        step("andi_aluwb", e_aluwb());
        set_instr(7'b0110011, 3'b110, 1'b0);
        step("or_fetch", e_fetch(1'b1));
        step("or_decode", e_decode(1'b0));
        step("or_execr", e_execr(3'b011));
        step("or_aluwb", e_aluwb());
        set_instr(7'b0010011, 3'b010, 1'b0);
        step("slti_fetch", e_fetch(1'b1));
        step("slti_decode", e_decode(1'b0));
        step("slti_execi", e_execi(3'b101, 1'b0));
        step("slti_aluwb", e_aluwb());

        // FETCH stall then load with three wait cycles
        set_instr(7'b0000011, 3'b010, 1'b0);
        MemReady = 1'b0;
        step("ld_fetch_wait", e_fetch(1'b0));
        MemReady = 1'b1;
        step("ld_fetch", e_fetch(1'b1));
        step("ld_decode", e_decode(1'b0));
        step("ld_memadr", e_memadr(2'b00));
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("ld_memread_wait", e_memread());
        end
        MemReady = 1'b1;
        step("ld_memread", e_memread());
        step("ld_memwb", e_memwb());
        step("ld_next_fetch", e_fetch(1'b1));

        // store
        set_instr(7'b0100011, 3'b010, 1'b0);
        step("st_decode", e_decode(1'b0));
        step("st_memadr", e_memadr(2'b01));
        step("st_memwrite", e_memwrite(1'b1));

        // beq taken on Zero
        set_instr(7'b1100011, 3'b000, 1'b0);
        Zero = 1'b1;
        step("beq_fetch", e_fetch(1'b1));
        step("beq_decode", e_decode(1'b0));
        step("beq_branch", e_branch(1'b1, 1'b0));
        Zero = 1'b0;

        // blt with N=V: not taken
        set_instr(7'b1100011, 3'b100, 1'b0);
        Negative = 1'b1; OverFlow = 1'b1;
        step("blt_fetch", e_fetch(1'b1));
        step("blt_decode", e_decode(1'b0));
        step("blt_branch", e_branch(1'b0, 1'b0));
        Negative = 1'b0; OverFlow = 1'b0;

        // bne with Zero=0 taken, bltu with Carry=0 taken, bgeu with Carry=0 not taken
        set_instr(7'b1100011, 3'b001, 1'b0);
        step("bne_fetch", e_fetch(1'b1));
        step("bne_decode", e_decode(1'b0));
        step("bne_branch", e_branch(1'b1, 1'b0));
        set_instr(7'b1100011, 3'b110, 1'b0);
        step("bltu_fetch", e_fetch(1'b1));
        step("bltu_decode", e_decode(1'b0));
        step("bltu_branch", e_branch(1'b1, 1'b0));
        set_instr(7'b1100011, 3'b111, 1'b0);
        step("bgeu_fetch", e_fetch(1'b1));
        step("bgeu_decode", e_decode(1'b0));
        step("bgeu_branch", e_branch(1'b0, 1'b0));

        // bge with N=1,V=0: not taken
        set_instr(7'b1100011, 3'b101, 1'b0);
        Negative = 1'b1;
        step("bge_fetch", e_fetch(1'b1));
        step("bge_decode", e_decode(1'b0));
        step("bge_branch", e_branch(1'b0, 1'b0));
        Negative = 1'b0;

        // branch funct3 010 is illegal and never taken
        set_instr(7'b1100011, 3'b010, 1'b0);
        Zero = 1'b1;
        step("bill_fetch", e_fetch(1'b1));
        step("bill_decode", e_decode(1'b0));
        step("bill_branch", e_branch(1'b0, 1'b1));
        Zero = 1'b0;

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0);
        step("jal_fetch", e_fetch(1'b1));
        step("jal_decode", e_decode(1'b0));
        step("jal_jal", e_jal());
        step("jal_aluwb", e_aluwb());

        // Unsupported opcode: one Illegal pulse, back to FETCH (held there by MemReady=0)
        set_instr(7'b1111111, 3'b000, 1'b0);
        step("ill_fetch", e_fetch(1'b1));
        MemReady = 1'b0;
        step("ill_decode", e_decode(1'b1));
        step("ill_next_fetch", e_fetch(1'b0));
        MemReady = 1'b1;

        // Reset during a MEMWRITE stall
        set_instr(7'b0100011, 3'b010, 1'b0);
        step("rst_fetch", e_fetch(1'b1));
        step("rst_decode", e_decode(1'b0));
        step("rst_memadr", e_memadr(2'b01));
        MemReady = 1'b0;
        step("rst_memwrite_wait", e_memwrite(1'b1));
        rst = 1'b1;
        step("rst_memwrite_rst", e_memwrite(1'b0));
        rst = 1'b0;
        MemReady = 1'b1;
        step("rst_after_fetch", e_fetch(1'b1));
        step("rst_after_decode", e_decode(1'b0));

        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-002 The block SHALL have these inputs:
- Opcode  input  7  instruction opcode field from the IR.
- Funct3  input  3  instruction funct3.
- Funct7b5  input  1  instruction bit 30.
- Zero, Negative, Carry, OverFlow  input  1 each  ALU flags.
- MemReady  input  1  memory access completes this cycle.
REQ-003 The block SHALL have these outputs:
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  IR and OldPC enable.
- RegWrite  output  1  register file write.
- ResultSrc  output  2  result select: 00=ALUOut, 01=Data, 10=ALU result.
- ALUSrcA  output  2  ALU A select: 00=PC, 01=OldPC, 10=RegA.
- ALUSrcB  output  2  ALU B select: 00=RegB, 01=Imm, 10=constant 4.
- ImmSrc  output  2  immediate format: 00=I, 01=S, 10=B, 11=J.
- ALUControl  output  3  ALU operation.
- Illegal  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-004 ALUControl SHALL use these encodings: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 set-less-than.
REQ-005 The FSM SHALL have these states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL.
REQ-006 FETCH behaviour:
- Outputs: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, add.
- IRWrite and PCWrite SHALL equal MemReady.
- The FSM SHALL stay in FETCH while MemReady=0 and go to DECODE when MemReady=1.
REQ-007 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ImmSrc=10 and add, then branch on Opcode:
- 0000011 (load) or 0100011 (store) -> MEMADR.
- 0110011 -> EXECR.
- 0010011 -> EXECI.
- 1100011 -> BRANCH.
- 1101111 -> JAL.
- Any other opcode -> FETCH, with Illegal=1 for that cycle.
REQ-008 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, add, and ImmSrc=00 for a load or 01 for a store; it then goes to MEMREAD for a load or MEMWRITE for a store.
REQ-009 MEMREAD SHALL drive AdrSrc=1 and hold until MemReady=1, then go to MEMWB.
REQ-010 MEMWB SHALL drive ResultSrc=01 and RegWrite=1, then go to FETCH.
REQ-011 MEMWRITE SHALL drive AdrSrc=1 and MemWrite=1, hold until MemReady=1, then go to FETCH.
REQ-012 EXECR SHALL drive ALUSrcA=10 and ALUSrcB=00 with ALUControl from the decode table, then go to ALUWB.
REQ-013 EXECI SHALL drive ALUSrcA=10, ALUSrcB=01 and ImmSrc=00 with ALUControl from the decode table, then go to ALUWB.
REQ-014 The decode table SHALL be, by Funct3:
- 000: sub only when R-type and Funct7b5=1, otherwise add.
- 010: slt.
- 100: xor.
- 110: or.
- 111: and.
- Others: add, with Illegal pulsed.
REQ-015 ALUWB SHALL drive ResultSrc=00 and RegWrite=1, then go to FETCH.
REQ-016 BRANCH SHALL drive ALUSrcA=10, ALUSrcB=00, sub and ResultSrc=00.
REQ-017 In BRANCH, PCWrite SHALL equal the taken condition for the current Funct3:
- 000: Zero.
- 001: ~Zero.
- 100: Negative^OverFlow.
- 101: ~(Negative^OverFlow).
- 110: ~Carry.
- 111: Carry.
- 010/011: 0, with Illegal pulsed.
REQ-018 BRANCH SHALL then go to FETCH.
REQ-019 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00 and PCWrite=1, then go to ALUWB.
REQ-020 Every output not named for a state SHALL be 0 in that state.
REQ-021 All outputs SHALL be combinational from the state and the inputs (Moore-plus-flag), with no output registers.
REQ-022 Instruction latency SHALL be, with MemReady=1 throughout: R/I/branch 3–4 cycles, load 5, store 4, jal 4.

Reset
REQ-023 rst=1 at a clock edge SHALL force FETCH, overriding any state, including a mid-MEMWRITE stall.
REQ-024 While rst=1, all write enables (PCWrite, IRWrite, RegWrite, MemWrite) and Illegal SHALL be 0.
REQ-025 After rst is released, the first FETCH cycle SHALL behave normally.

Structure
REQ-026 A shared package SHALL hold the state enum, the ALUControl codes, the opcode constants, and the ImmSrc and ResultSrc encodings.
REQ-027 A combinational sub-module alu_decoder (inputs Opcode, Funct3, Funct7b5, ALUOp; outputs ALUControl, illegal_funct) SHALL implement REQ-014, instantiated once.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- add x (Opcode 0110011, Funct3 000, Funct7b5 0), MemReady=1 -> states FETCH, DECODE, EXECR, ALUWB; ALUControl=000 in EXECR; RegWrite=1 only in ALUWB.
- sub (Funct7b5=1) -> ALUControl=001 in EXECR; addi with bit30=1 -> ALUControl=000.
- Load with MemReady held 0 for 3 cycles in MEMREAD -> AdrSrc=1 for 4 cycles; MEMWB follows; RegWrite pulses exactly once.
- beq with Zero=1 -> PCWrite=1 in BRANCH; blt with Negative=1, OverFlow=1 -> PCWrite=0.
- Opcode 1111111 in DECODE -> Illegal=1 for one cycle, next state FETCH, no write enable asserted.
- rst asserted during a MEMWRITE stall -> MemWrite=0 from that edge, state FETCH next cycle.
